// File: rtl/addsub_result_stage.sv
// addsub_result_stage
//   Registered output stage behind the 4-bit ripple add/sub unit. Each accepted
//   result is stored with its mode and status flags (carry/borrow, zero,
//   negative, signed overflow) in a 2-entry FIFO. A saturating counter tracks
//   accepted results that overflowed.
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   in_valid/in_ready         upstream handshake; in_ready depends on fill level only
//   in_s, in_cout, in_m       add/sub unit result, carry out c4, mode (1 = subtract)
//   in_a3, in_b3              operand MSBs (in_b3 raw, before the mode XOR)
//   out_valid/out_ready       downstream handshake for the head entry
//   out_res, out_c, out_z,
//   out_n, out_v, out_m       head entry result, flags and mode
//   ovf_cnt, ovf_clr          saturating overflow count, synchronous clear
module addsub_result_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_s,
    input  logic             in_cout,
    input  logic             in_m,
    input  logic             in_a3,
    input  logic             in_b3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_res,
    output logic             out_c,
    output logic             out_z,
    output logic             out_n,
    output logic             out_v,
    output logic             out_m,
    output logic [CNT_W-1:0] ovf_cnt,
    input  logic             ovf_clr
);

    // Entry layout: {m, v, n, z, c, res[3:0]}
    localparam logic [1:0]       FULL_CNT = DEPTH[1:0];
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Builds a stored entry, deriving the flags from the raw add/sub outputs.
    // In subtract mode the unit adds ~B, so the effective B sign is b3^m and the
    // carry out is the inverse of a borrow.
    function automatic logic [8:0] make_entry(
        input logic [3:0] s,
        input logic       cout,
        input logic       m,
        input logic       a3,
        input logic       b3
    );
        logic bx;
        logic v;
        logic c;
        logic z;
        logic n;
        bx = b3 ^ m;
        v  = (a3 == bx) & (s[3] != a3);
        c  = m ? ~cout : cout;
        z  = ~|s;
        n  = s[3];
        return {m, v, n, z, c, s};
    endfunction

    logic [8:0]       mem_r [0:1];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [8:0]       head_r;
    logic [CNT_W-1:0] ovf_cnt_r;

    logic             push_s;
    logic             pop_s;
    logic [8:0]       entry_s;
    logic [1:0]       count_nxt_s;
    logic             rd_ptr_nxt_s;
    logic [8:0]       head_nxt_s;

    assign push_s  = in_valid & in_ready_r;
    assign pop_s   = out_valid_r & out_ready;
    assign entry_s = make_entry(in_s, in_cout, in_m, in_a3, in_b3);

    // Next fill level, next read pointer and the entry that will sit at the head.
    always_comb begin
        count_nxt_s  = count_r;
        rd_ptr_nxt_s = rd_ptr_r;
        head_nxt_s   = mem_r[rd_ptr_r];
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
        if (pop_s) begin
            rd_ptr_nxt_s = ~rd_ptr_r;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        // The new head is the entry being written when the FIFO was empty, or
        // when the only stored entry is popped in the same cycle.
        if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = entry_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Entry storage and write pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_r[0] <= 9'd0;
            mem_r[1] <= 9'd0;
            wr_ptr_r <= 1'b0;
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= entry_s;
            wr_ptr_r        <= ~wr_ptr_r;
        end
    end

    // Fill level, read pointer and the registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r     <= 2'd0;
            rd_ptr_r    <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            in_ready_r  <= (count_nxt_s != FULL_CNT);
            out_valid_r <= (count_nxt_s != 2'd0);
        end
    end

    // Head-entry output register; holds its last value while the FIFO is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r <= 9'd0;
        end else if (count_nxt_s != 2'd0) begin
            head_r <= head_nxt_s;
        end
    end

    // Saturating overflow counter; a clear overrides a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt_r <= {CNT_W{1'b0}};
        end else if (ovf_clr) begin
            ovf_cnt_r <= {CNT_W{1'b0}};
        end else if (push_s && entry_s[7] && (ovf_cnt_r != CNT_MAX)) begin
            ovf_cnt_r <= ovf_cnt_r + CNT_ONE;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_res   = head_r[3:0];
    assign out_c     = head_r[4];
    assign out_z     = head_r[5];
    assign out_n     = head_r[6];
    assign out_v     = head_r[7];
    assign out_m     = head_r[8];
    assign ovf_cnt   = ovf_cnt_r;

endmodule

// File: tb/tb_addsub_result_stage.sv
// tb_addsub_result_stage
//   Directed bench for addsub_result_stage. Stimulus is given as real operands
//   (mode, A, B); the bench forms what the ripple unit would present and keeps
//   an arithmetic model (queue of expected entries, overflow count) that a
//   negedge compare process checks every cycle, plus hand-computed literals.
module tb_addsub_result_stage;

    typedef struct packed {
        logic [3:0] res;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
        logic       m;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_s;
    logic       in_cout;
    logic       in_m;
    logic       in_a3;
    logic       in_b3;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_res;
    logic       out_c;
    logic       out_z;
    logic       out_n;
    logic       out_v;
    logic       out_m;
    logic [7:0] ovf_cnt;
    logic       ovf_clr;

    logic [3:0] cur_a;
    logic [3:0] cur_b;
    logic       cur_m;

    exp_t mq[$];
    int   mcnt;
    int   n_checks;
    int   n_fail;
    logic chk_en;

    addsub_result_stage #(.DEPTH(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_s(in_s), .in_cout(in_cout), .in_m(in_m), .in_a3(in_a3), .in_b3(in_b3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_c(out_c), .out_z(out_z), .out_n(out_n),
        .out_v(out_v), .out_m(out_m),
        .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    function automatic int sx(input logic [3:0] x);
        return x[3] ? (int'(x) - 16) : int'(x);
    endfunction

    // Expected entry from plain integer arithmetic on the operands.
    function automatic exp_t expect_of(input logic m, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        int   ur;
        int   sr;
        ur    = m ? (int'(a) - int'(b)) : (int'(a) + int'(b));
        sr    = m ? (sx(a) - sx(b)) : (sx(a) + sx(b));
        e.res = ur[3:0];
        e.c   = m ? (a < b) : (ur > 15);
        e.v   = (sr > 7) || (sr < -8);
        e.z   = (e.res == 4'd0);
        e.n   = e.res[3];
        e.m   = m;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Presents what the ripple add/sub unit produces for the given operands.
    task automatic drive(input logic v, input logic m, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] full;
        full     = m ? ({1'b0, a} + {1'b0, ~b} + 5'd1) : ({1'b0, a} + {1'b0, b});
        in_valid = v;
        cur_m    = m;
        cur_a    = a;
        cur_b    = b;
        in_s     = full[3:0];
        in_cout  = full[4];
        in_m     = m;
        in_a3    = a[3];
        in_b3    = b[3];
    endtask

    // One clock: the model advances at the edge, the bench resumes after negedge.
    task automatic tick();
        logic dpush;
        logic dpop;
        exp_t e;
        dpush = in_valid && (mq.size() < 2);
        dpop  = (mq.size() > 0) && out_ready;
        e     = expect_of(cur_m, cur_a, cur_b);
        @(posedge clk);
        if (!rst) begin
            if (dpop) void'(mq.pop_front());
            if (dpush) mq.push_back(e);
            if (ovf_clr) mcnt = 0;
            else if (dpush && e.v && (mcnt < 255)) mcnt++;
        end
        @(negedge clk);
        #1;
    endtask

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("in_ready", {31'd0, in_ready}, {31'd0, mq.size() != 2});
                check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
                check("ovf_cnt", {24'd0, ovf_cnt}, mcnt);
                if (mq.size() > 0) begin
                    check("head", {23'd0, out_res, out_c, out_z, out_n, out_v, out_m},
                          {23'd0, mq[0]});
                end
            end
        end
    end

    initial begin
        int acc;
        n_checks  = 0;
        n_fail    = 0;
        mcnt      = 0;
        chk_en    = 1'b0;
        rst       = 1'b1;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        #1;
        chk_en = 1'b1;

        // 1: reset over two cycles
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_outputs", {26'd0, out_res, out_c, out_z}, 32'd0);
        check("rst_flags", {29'd0, out_n, out_v, out_m}, 32'd0);
        check("rst_ovf_cnt", {24'd0, ovf_cnt}, 32'd0);
        rst = 1'b0;
        tick();

        // 2: 3+5 overflows into the sign bit
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 4'd3, 4'd5);
        tick();
        check("add35_valid", {31'd0, out_valid}, 32'd1);
        check("add35_res", {28'd0, out_res}, 32'd8);
        check("add35_czn_v", {28'd0, out_c, out_z, out_n, out_v}, 32'b0011);
        check("add35_ovf_cnt", {24'd0, ovf_cnt}, 32'd1);

        // 3: 2-2 then 2-3
        drive(1'b1, 1'b1, 4'd2, 4'd2);
        tick();
        check("sub22_res", {28'd0, out_res}, 32'd0);
        check("sub22_czv_m", {28'd0, out_c, out_z, out_v, out_m}, 32'b0101);
        drive(1'b1, 1'b1, 4'd2, 4'd3);
        tick();
        check("sub23_res", {28'd0, out_res}, 32'd15);
        check("sub23_cnv", {29'd0, out_c, out_n, out_v}, 32'b110);
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        tick();

        // 4: backpressure with R1=0+1, R2=0+2, R3=0+3
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 4'd0, 4'd1);
        tick();
        drive(1'b1, 1'b0, 4'd0, 4'd2);
        tick();
        drive(1'b1, 1'b0, 4'd0, 4'd3);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        tick();
        check("held_head", {28'd0, out_res}, 32'd1);
        out_ready = 1'b1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            if (in_ready) acc = 1;
            tick();
            if (acc == 1) break;
        end
        check("r3_accepted", acc, 32'd1);
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        check("r3_head", {28'd0, out_res}, 32'd3);
        tick();
        check("drained_valid", {31'd0, out_valid}, 32'd0);
        check("drained_hold_res", {28'd0, out_res}, 32'd3);

        // 5: saturate the overflow counter, then clear against an overflow push
        acc = 0;
        drive(1'b1, 1'b0, 4'd3, 4'd5);
        for (int i = 0; i < 600 && acc < 260; i++) begin
            if (in_ready) acc++;
            tick();
        end
        check("sat_pushes", acc, 32'd260);
        check("sat_ovf_cnt", {24'd0, ovf_cnt}, 32'd255);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("clr_wins", {24'd0, ovf_cnt}, 32'd0);
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        tick();
        tick();

        // 6: reset with two entries loaded
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 4'd1, 4'd1);
        tick();
        drive(1'b1, 1'b0, 4'd2, 4'd2);
        tick();
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        check("loaded_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        mq.delete();
        mcnt = 0;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_res", {28'd0, out_res}, 32'd0);
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 4'd2, 4'd3);
        tick();
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        check("post_rst_valid", {31'd0, out_valid}, 32'd1);
        check("post_rst_res", {28'd0, out_res}, 32'd5);
        out_ready = 1'b1;
        tick();
        tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
